// File: rtl/byte_assembler_pkg.sv
// Shared constants, FSM encoding and the bytes-per-word / offset-width derivation
// for the instruction byte assembler.
package byte_assembler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int nb_of(input int n);
    return n / BYTE_W;
  endfunction

  // A single-byte word still needs a 1-bit offset port.
  function automatic int cw_of(input int n);
    return (n / BYTE_W > 1) ? $clog2(n / BYTE_W) : 1;
  endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// One byte lane of the assembled word: 8-bit register, synchronous active-low clear
// that wins over the write enable.
module byte_lane_reg
  import byte_assembler_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clr_,
  input  logic              i_we,
  input  logic [BYTE_W-1:0] i_d,
  output logic [BYTE_W-1:0] o_q
);

  logic [BYTE_W-1:0] dat_q;
  logic [BYTE_W-1:0] dat_d;

  always_comb begin
    dat_d = dat_q;
    if (!i_clr_) begin
      dat_d = '0;
    end else if (i_we) begin
      dat_d = i_d;
    end
  end

  always_ff @(posedge i_clk) begin
    dat_q <= dat_d;
  end

  assign o_q = dat_q;

endmodule

// File: rtl/byte_assembler.sv
// Packs NB little-endian bytes into one n-bit word; word valid the cycle after the last
// byte. One HOLD cycle per word; byte side stalls while the word waits for the consumer.
module byte_assembler
  import byte_assembler_pkg::*;
#(
  parameter  int n  = 32,
  localparam int NB = nb_of(n),
  localparam int CW = cw_of(n)
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  input  logic              i_flush,
  output logic [n-1:0]      o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [CW-1:0]     o_count
);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            byte_acc;
  logic            word_acc;
  logic            lane_clr_;

  assign o_byte_ready = (state_q == FILL);
  assign o_word_valid = (state_q == HOLD);
  assign o_count      = count_q;

  assign byte_acc  = i_byte_valid & o_byte_ready;
  assign word_acc  = o_word_valid & i_word_ready;
  assign lane_clr_ = i_rst_ & ~i_flush;

  // Flush outranks both handshakes; byte and word accept are exclusive by state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (i_flush) begin
      state_d = FILL;
      count_d = '0;
    end else if (word_acc) begin
      state_d = FILL;
    end else if (byte_acc) begin
      if (count_q == CW'(NB - 1)) begin
        count_d = '0;
        state_d = HOLD;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    byte_lane_reg u_lane (
      .i_clk  (i_clk),
      .i_clr_ (lane_clr_),
      .i_we   (byte_acc & (count_q == CW'(i))),
      .i_d    (i_byte),
      .o_q    (o_word[i*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_byte_assembler.sv
// Directed stimulus with a word scoreboard; a negedge monitor checks every consumed word.
module tb_byte_assembler;

  logic        i_clk = 1'b0;
  logic        i_rst_ = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic        i_flush = 1'b0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready = 1'b0;
  logic [1:0]  o_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 i_clk = ~i_clk;

  byte_assembler #(.n(32)) dut (
    .i_clk        (i_clk),
    .i_rst_       (i_rst_),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .i_flush      (i_flush),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_count      (o_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Holds the byte until the assembler takes it, bounded.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    i_byte = b;
    i_byte_valid = 1'b1;
    waited = 0;
    while (!o_byte_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!o_byte_ready) begin
      chk("byte_ready_timeout", 32'(o_byte_ready), 32'd1);
    end else begin
      tick();
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    i_word_ready = 1'b1;
    waited = 0;
    while (o_word_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("drain_done", 32'(o_word_valid), 32'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_count"}, 32'(o_count), 32'd0);
    chk({name, "_word"}, o_word, 32'h0);
    chk({name, "_bready"}, 32'(o_byte_ready), 32'd1);
    chk({name, "_wvalid"}, 32'(o_word_valid), 32'd0);
  endtask

  // Monitor: a word is consumed at the next edge when valid & ready without flush/reset.
  always @(negedge i_clk) begin
    if (i_rst_ && !i_flush && o_word_valid && i_word_ready) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL word_unexpected: got %h expected none", o_word);
      end else begin
        chk("word_out", o_word, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1 [4];
    logic [1:0] pat_val;
    logic       pat [7];
    logic [7:0] bb [12];
    int acc;
    int bi;

    s1 = '{8'h78, 8'h56, 8'h34, 8'h12};

    // Reset and basic word
    tick(); tick();
    i_rst_ = 1'b1;
    chk_idle("reset");
    i_word_ready = 1'b1;
    sb.push_back(32'h12345678);
    for (int k = 0; k < 4; k++) begin
      chk("t1_count", 32'(o_count), 32'(k));
      send_byte(s1[k]);
    end
    chk("t1_wvalid", 32'(o_word_valid), 32'd1);
    chk("t1_word", o_word, 32'h12345678);
    chk("t1_count_wrap", 32'(o_count), 32'd0);
    tick();

    // Consumer stall: held word, fifth byte waits
    i_word_ready = 1'b0;
    sb.push_back(32'h12345678);
    for (int k = 0; k < 4; k++) send_byte(s1[k]);
    i_byte = 8'hAA;
    i_byte_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_word", o_word, 32'h12345678);
      chk("t2_hold_wvalid", 32'(o_word_valid), 32'd1);
      chk("t2_hold_bready", 32'(o_byte_ready), 32'd0);
      chk("t2_hold_count", 32'(o_count), 32'd0);
      tick();
    end
    i_word_ready = 1'b1;
    tick();
    sb.push_back(32'h332211AA);
    send_byte(8'hAA);
    chk("t2_aa_count", 32'(o_count), 32'd1);
    chk("t2_aa_lane0", 32'(o_word[7:0]), 32'h000000AA);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t2_word", o_word, 32'h332211AA);
    drain();

    // Gapped byte stream
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    sb.push_back(32'h04030201);
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      chk("t3_count", 32'(o_count), 32'(acc % 4));
      i_byte_valid = pat[k];
      i_byte = 8'(acc + 1);
      tick();
      if (pat[k]) acc++;
    end
    i_byte_valid = 1'b0;
    chk("t3_wvalid", 32'(o_word_valid), 32'd1);
    chk("t3_word", o_word, 32'h04030201);
    drain();

    // Flush mid-word drops partial word and a same-cycle byte
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t4_pre_count", 32'(o_count), 32'd2);
    i_flush = 1'b1;
    i_byte = 8'h33;
    i_byte_valid = 1'b1;
    tick();
    i_flush = 1'b0;
    i_byte_valid = 1'b0;
    chk("t4_flush_count", 32'(o_count), 32'd0);
    chk("t4_flush_word", o_word, 32'h0);
    sb.push_back(32'hAABBCCDD);
    send_byte(8'hDD);
    send_byte(8'hCC);
    send_byte(8'hBB);
    send_byte(8'hAA);
    chk("t4_word", o_word, 32'hAABBCCDD);
    drain();

    // Flush beats word accept in HOLD
    i_word_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk_idle("t5_flush_hold");

    // Reset mid-word
    send_byte(8'h55);
    send_byte(8'h66);
    i_rst_ = 1'b0;
    tick();
    i_rst_ = 1'b1;
    chk_idle("t5_reset_mid");

    // Back-to-back words, consumer always ready
    for (int k = 0; k < 12; k++) bb[k] = 8'(k * 7 + 1);
    for (int j = 0; j < 3; j++) begin
      sb.push_back({bb[4*j+3], bb[4*j+2], bb[4*j+1], bb[4*j]});
    end
    bi = 0;
    for (int c = 0; c < 15; c++) begin
      pat_val = 2'(c % 5 == 4);
      chk("t6_wvalid", 32'(o_word_valid), 32'(pat_val));
      chk("t6_bready", 32'(o_byte_ready), 32'(pat_val == 2'd0));
      i_byte = bb[bi];
      i_byte_valid = 1'b1;
      if (o_byte_ready && bi < 11) bi++;
      tick();
    end
    i_byte_valid = 1'b0;
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
